mem_port_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one single-port memory (1<<addr_width words)

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port memory between num_req clients.
// One access in flight at a time; read data is routed back to the requester that won.
module mem_port_arbiter #(
  parameter int addr_width   = 12,
  parameter int data_width   = 16,
  parameter int num_req      = 3,
  parameter int read_latency = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [num_req-1:0]             req,
  input  logic [num_req-1:0]             req_we,
  input  logic [num_req*addr_width-1:0]  req_addr,
  input  logic [num_req*data_width-1:0]  req_wdata,
  output logic [num_req-1:0]             gnt,
  output logic [num_req-1:0]             rvalid,
  output logic [data_width-1:0]          rdata,
  output logic                           busy,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [addr_width-1:0]          mem_addr,
  output logic [data_width-1:0]          mem_wdata,
  input  logic [data_width-1:0]          mem_rdata
);

  localparam int PTR_W = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [PTR_W-1:0]      win, cand;
  logic [PTR_W:0]        sum;
  logic                  found;
  logic [3:0]            cnt_q, cnt_d;
  logic [num_req-1:0]    gnt_d, rvalid_d;
  logic [data_width-1:0] rdata_d;
  logic                  busy_d;
  logic                  mem_en_d, mem_we_d;
  logic [addr_width-1:0] mem_addr_d;
  logic [data_width-1:0] mem_wdata_d;

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    sum   = '0;
    for (int i = 0; i < num_req; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(num_req))
        sum = sum - (PTR_W+1)'(num_req);
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = ISSUE;
          gnt_d[win]   = 1'b1;
          mem_en_d     = 1'b1;
          mem_we_d     = req_we[win];
          mem_addr_d   = req_addr[int'(win)*addr_width +: addr_width];
          mem_wdata_d  = req_wdata[int'(win)*data_width +: data_width];
          owner_d      = win;
          ptr_d        = (win == PTR_W'(num_req-1)) ? '0 : win + PTR_W'(1);
        end
      end
      ISSUE: begin
        if (mem_we) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = 4'(read_latency - 1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d           = mem_rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Every output is a flop so downstream timing never sees the arbitration logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      rvalid    <= rvalid_d;
      rdata     <= rdata_d;
      busy      <= busy_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, checked
// every cycle against a transaction-level model of grants, read returns and memory contents.
module tb_mem_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic             busy, mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .addr_width(AW), .data_width(DW), .num_req(NR), .read_latency(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return {a[3:0], a} ^ 16'hA5C3;
  endfunction

  // Memory device with a fixed read pipeline; unwritten words return initVal.
  logic [DW-1:0] dev_mem [1<<AW];
  bit            dev_wr  [1<<AW];
  logic [DW-1:0] pipe    [RL];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      dev_mem[mem_addr] <= mem_wdata;
      dev_wr[mem_addr]  <= 1'b1;
    end
    pipe[0] <= dev_wr[mem_addr] ? dev_mem[mem_addr] : initVal(mem_addr);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RL-1];

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level reference state.
  int cur = 0;
  int ptr_m = 0;
  int idle_from = 0;
  int sel_cyc = -100;
  logic [NR-1:0] sch_gnt [64];
  logic [NR-1:0] sch_rv  [64];
  bit            sch_en  [64];
  logic [DW-1:0] sch_rd  [64];
  logic [NR-1:0] last_gnt;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;
  logic [DW-1:0] ref_mem [1<<AW];

  bit            rq_act  [NR];
  bit            rq_hold [NR];
  logic          rq_we   [NR];
  logic [AW-1:0] rq_addr [NR];
  logic [DW-1:0] rq_wdata[NR];
  bit            rnd_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NR; i++) begin
      req[i]                = rq_act[i];
      req_we[i]             = rq_we[i];
      req_addr[i*AW +: AW]  = rq_addr[i];
      req_wdata[i*DW +: DW] = rq_wdata[i];
    end
  endtask

  task automatic clearRequesters();
    for (int i = 0; i < NR; i++) begin
      rq_act[i] = 1'b0; rq_hold[i] = 1'b0; rq_we[i] = 1'b0;
      rq_addr[i] = '0; rq_wdata[i] = '0;
    end
    driveInputs();
  endtask

  task automatic setReq(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit hold);
    rq_act[i] = 1'b1; rq_we[i] = we; rq_addr[i] = a; rq_wdata[i] = d; rq_hold[i] = hold;
  endtask

  task automatic modelReset();
    ptr_m = 0; idle_from = cur; sel_cyc = -100;
    for (int i = 0; i < 64; i++) begin
      sch_gnt[i] = '0; sch_rv[i] = '0; sch_en[i] = 1'b0; sch_rd[i] = '0;
    end
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; last_gnt = '0;
  endtask

  // Drives this cycle's requests and, if the arbiter is free, predicts the transaction.
  task automatic applyStimulus();
    int w, s, r;
    logic [NR-1:0] one;
    driveInputs();
    if (cur >= idle_from && req != '0) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && rq_act[(ptr_m + k) % NR]) w = (ptr_m + k) % NR;
      one = NR'(1) << w;
      s = (cur + 1) % 64;
      sch_gnt[s] = one;
      sch_en[s]  = 1'b1;
      exp_we = rq_we[w]; exp_addr = rq_addr[w]; exp_wdata = rq_wdata[w];
      ptr_m = (w + 1) % NR;
      sel_cyc = cur;
      if (rq_we[w]) begin
        ref_mem[rq_addr[w]] = rq_wdata[w];
        idle_from = cur + 2;
      end else begin
        r = (cur + 2 + RL) % 64;
        sch_rv[r] = one;
        sch_rd[r] = ref_mem[rq_addr[w]];
        idle_from = cur + 2 + RL;
      end
    end
  endtask

  task automatic checkOutput();
    int s;
    s = cur % 64;
    if (sch_rv[s] != '0) exp_rdata = sch_rd[s];
    chk("gnt",       32'(gnt),       32'(sch_gnt[s]));
    chk("rvalid",    32'(rvalid),    32'(sch_rv[s]));
    chk("mem_en",    32'(mem_en),    32'(sch_en[s]));
    chk("busy",      32'(busy),      32'((cur > sel_cyc) && (cur < idle_from)));
    chk("mem_we",    32'(mem_we),    32'(exp_we));
    chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    chk("rdata",     32'(rdata),     32'(exp_rdata));
    last_gnt = sch_gnt[s];
    sch_gnt[s] = '0; sch_rv[s] = '0; sch_en[s] = 1'b0;
  endtask

  task automatic newCmd(input int i);
    setReq(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           DW'($urandom), 1'b0);
  endtask

  task automatic reactToGrants();
    for (int i = 0; i < NR; i++) begin
      if (last_gnt[i]) begin
        if (rnd_mode) begin
          if ($urandom_range(0, 1) == 1) newCmd(i); else rq_act[i] = 1'b0;
        end else if (!rq_hold[i]) begin
          rq_act[i] = 1'b0;
        end
      end else if (rnd_mode) begin
        if (!rq_act[i] && $urandom_range(0, 9) < 3) newCmd(i);
        else if (rq_act[i] && $urandom_range(0, 19) == 0) rq_act[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    applyStimulus();
    @(posedge clk);
    @(negedge clk);
    cur++;
    checkOutput();
    reactToGrants();
  endtask

  task automatic checkZeros(input string tag);
    chk({tag, "_gnt"},       32'(gnt),       32'(0));
    chk({tag, "_rvalid"},    32'(rvalid),    32'(0));
    chk({tag, "_rdata"},     32'(rdata),     32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_mem_en"},    32'(mem_en),    32'(0));
    chk({tag, "_mem_we"},    32'(mem_we),    32'(0));
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
  endtask

  // Called at a falling edge: asserts reset mid-cycle and releases it two cycles later.
  task automatic doReset(input string tag);
    clearRequesters();
    rst_n = 1'b0;
    #1;
    checkZeros(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [NR-1:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = initVal(AW'(i));
    clearRequesters();
    modelReset();
    rst_n = 1'b1;

    $display("[TB] reset while running");
    @(negedge clk);
    doReset("rst");
    step();
    chk("post_reset_busy", 32'(busy), 32'(0));

    $display("[TB] single write");
    setReq(0, 1'b1, 12'h123, 16'hBEEF, 1'b0);
    step();
    chk("wr_gnt",   32'(gnt),       32'(3'b001));
    chk("wr_en",    32'(mem_en),    32'(1));
    chk("wr_we",    32'(mem_we),    32'(1));
    chk("wr_addr",  32'(mem_addr),  32'(12'h123));
    chk("wr_wdata", 32'(mem_wdata), 32'(16'hBEEF));
    step();
    chk("wr_busy_after", 32'(busy), 32'(0));

    $display("[TB] single read");
    setReq(1, 1'b0, 12'h123, 16'h0000, 1'b0);
    step();
    chk("rd_gnt", 32'(gnt), 32'(3'b010));
    step(); step(); step();
    chk("rd_rvalid", 32'(rvalid), 32'(3'b010));
    chk("rd_rdata",  32'(rdata),  32'(16'hBEEF));
    step();

    $display("[TB] fairness with all requesters writing");
    doReset("rst4");
    setReq(0, 1'b1, 12'h010, 16'h1111, 1'b1);
    setReq(1, 1'b1, 12'h011, 16'h2222, 1'b1);
    setReq(2, 1'b1, 12'h012, 16'h3333, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(order[k]));
      step();
    end
    clearRequesters();
    repeat (3) step();

    $display("[TB] read contending with write");
    doReset("rst5");
    setReq(0, 1'b0, 12'h123, 16'h0000, 1'b0);
    setReq(2, 1'b1, 12'h456, 16'h1234, 1'b0);
    step();
    chk("ct_gnt0", 32'(gnt), 32'(3'b001));
    step(); step(); step();
    chk("ct_rvalid", 32'(rvalid), 32'(3'b001));
    chk("ct_rdata",  32'(rdata),  32'(16'hBEEF));
    step();
    chk("ct_gnt2", 32'(gnt),      32'(3'b100));
    chk("ct_addr", 32'(mem_addr), 32'(12'h456));
    repeat (2) step();

    $display("[TB] reset during a read");
    setReq(1, 1'b0, 12'h020, 16'h0000, 1'b0);
    step();
    chk("rr_rd_gnt", 32'(gnt), 32'(3'b010));
    step();
    doReset("rst6");
    setReq(2, 1'b1, 12'h030, 16'h5555, 1'b0);
    step();
    chk("rst6_gnt", 32'(gnt), 32'(3'b100));
    repeat (5) begin
      step();
      chk("rst6_no_rvalid", 32'(rvalid), 32'(0));
    end

    $display("[TB] random traffic");
    rnd_mode = 1'b1;
    repeat (400) step();
    rnd_mode = 1'b0;
    clearRequesters();
    repeat (2 + RL + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
